ahb_cmd_fifo: RTL and testbench

AHB_CMD_FIFO -- requirements
Module: ahb_cmd_fifo

---
 rtl/ahb_cmd_fifo.sv | 113 +++++++++++
 tb/tb_ahb_cmd_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_fifo.sv
// ahb_cmd_fifo: first-word-fall-through command FIFO for AHB-style transfers.
// Each entry holds {write, addr, data, size} in a circular buffer of DEPTH entries.
//
// Parameters:
//   BUS_WIDTH  address/data width
//   DEPTH      entry count (power of 2, >= 2)
//
// Ports:
//   HCLK                 clock; all state updates on the rising edge
//   HRESETn              asynchronous active-low reset
//   push                 enqueue request
//   push_write           command type (1 = write, 0 = read)
//   push_addr/push_data  command address / write data (data stored for reads too)
//   push_size            HSIZE code
//   pop                  dequeue request
//   pop_write/addr/data/size  head entry; all zero while empty
//   empty/full/count     occupancy status
//   overflow/underflow   sticky error flags, present only with AHB_CMD_FIFO_ERR_EN
//
// Optional feature macro: AHB_CMD_FIFO_ERR_EN
module ahb_cmd_fifo #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       push,
    input  logic                       push_write,
    input  logic [BUS_WIDTH-1:0]       push_addr,
    input  logic [BUS_WIDTH-1:0]       push_data,
    input  logic [2:0]                 push_size,
    input  logic                       pop,
    output logic                       pop_write,
    output logic [BUS_WIDTH-1:0]       pop_addr,
    output logic [BUS_WIDTH-1:0]       pop_data,
    output logic [2:0]                 pop_size,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
`ifdef AHB_CMD_FIFO_ERR_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = 1 + 2 * BUS_WIDTH + 3;

    logic [EntryW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;
    logic [EntryW-1:0] head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign count = count_q;

    // A full FIFO still accepts a push when the same edge frees the head slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);

    always_comb begin
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge HCLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {push_write, push_addr, push_data, push_size};
        end
    end

    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign {pop_write, pop_addr, pop_data, pop_size} = head;

`ifdef AHB_CMD_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    // A push+pop on an empty FIFO is a legal push, so it does not flag underflow.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push & full & ~pop)  overflow_q  <= 1'b1;
            if (pop & empty & ~push) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_ahb_cmd_fifo.sv
// Testbench for ahb_cmd_fifo: directed stimulus feeding a scoreboard queue, with a
// separate monitor that checks every head entry consumed by the DUT.
module tb_ahb_cmd_fifo;

    localparam int unsigned BW = 32;
    localparam int unsigned DP = 8;

    typedef logic [2*BW+3:0] entry_t;

    logic          HCLK;
    logic          HRESETn;
    logic          push;
    logic          push_write;
    logic [BW-1:0] push_addr;
    logic [BW-1:0] push_data;
    logic [2:0]    push_size;
    logic          pop;
    logic          pop_write;
    logic [BW-1:0] pop_addr;
    logic [BW-1:0] pop_data;
    logic [2:0]    pop_size;
    logic          empty;
    logic          full;
    logic [3:0]    count;
`ifdef AHB_CMD_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    int     n_cmp = 0;
    int     n_bad = 0;
    entry_t sb[$];

    ahb_cmd_fifo #(
        .BUS_WIDTH(BW),
        .DEPTH    (DP)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .push      (push),
        .push_write(push_write),
        .push_addr (push_addr),
        .push_data (push_data),
        .push_size (push_size),
        .pop       (pop),
        .pop_write (pop_write),
        .pop_addr  (pop_addr),
        .pop_data  (pop_data),
        .pop_size  (pop_size),
        .empty     (empty),
        .full      (full),
        .count     (count)
`ifdef AHB_CMD_FIFO_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge and held for one cycle.
    // acc marks whether the push is expected to be accepted.
    task automatic step(input logic p, input logic w, input logic [BW-1:0] a,
                        input logic [BW-1:0] d, input logic [2:0] s,
                        input logic q, input logic acc);
        push       = p;
        push_write = w;
        push_addr  = a;
        push_data  = d;
        push_size  = s;
        pop        = q;
        if (p && acc) sb.push_back({w, a, d, s});
        @(posedge HCLK);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Monitor: on the falling edge, a pop against a non-empty FIFO will consume
    // the head at the next rising edge; compare it with the oldest expected entry.
    always @(negedge HCLK) begin
        if (HRESETn && pop && !empty) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL head: got addr 0x%0h expected no entry", pop_addr);
            end else begin
                entry_t exp_e;
                exp_e = sb.pop_front();
                if ({pop_write, pop_addr, pop_data, pop_size} !== exp_e) begin
                    n_bad++;
                    $display("FAIL head: got 0x%0h expected 0x%0h",
                             {pop_write, pop_addr, pop_data, pop_size}, exp_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        HRESETn    = 1'b0;
        push       = 1'b0;
        push_write = 1'b0;
        push_addr  = '0;
        push_data  = '0;
        push_size  = '0;
        pop        = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Reset release state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_pop_addr", pop_addr, 0);

        // Two commands, fall-through head, then drain
        step(1, 1, 32'h10, 32'hAA, 3'd2, 0, 1);
        chk("fwft_write", pop_write, 1);
        chk("fwft_addr", pop_addr, 32'h10);
        chk("fwft_data", pop_data, 32'hAA);
        chk("fwft_size", pop_size, 2);
        step(1, 0, 32'h20, 32'h0, 3'd2, 0, 1);
        chk("two_count", count, 2);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("pop1_write", pop_write, 0);
        chk("pop1_addr", pop_addr, 32'h20);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("pop2_empty", empty, 1);

        // Pop on empty is ignored
        step(0, 0, 0, 0, 0, 1, 0);
        chk("uf_count", count, 0);
        chk("uf_addr", pop_addr, 0);
        chk("uf_data", pop_data, 0);
        chk("uf_empty", empty, 1);
`ifdef AHB_CMD_FIFO_ERR_EN
        chk("uf_flag", underflow, 1);
        chk("uf_no_of", overflow, 0);
`endif

        // Fill to DEPTH, ninth push dropped, drain in order
        for (int i = 0; i < 8; i++) begin
            step(1, i[0], i, 32'h100 + i, 3'd2, 0, 1);
        end
        chk("fill_count7", count, 8);
        step(1, 1, 32'h8, 32'h108, 3'd2, 0, 0);
        chk("of_full", full, 1);
        chk("of_count", count, 8);
        chk("of_head", pop_addr, 0);
`ifdef AHB_CMD_FIFO_ERR_EN
        chk("of_flag", overflow, 1);
`endif
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
        end
        chk("drain_empty", empty, 1);
        chk("drain_sb", sb.size(), 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 32'h40 + i, 32'h500 + i, 3'd1, 0, 1);
        end
        step(1, 1, 32'h99, 32'h5A5A, 3'd0, 1, 1);
        chk("pp_count", count, 8);
        chk("pp_full", full, 1);
        chk("pp_head", pop_addr, 32'h41);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
        end
        chk("pp_last_addr", pop_addr, 32'h99);
        chk("pp_last_data", pop_data, 32'h5A5A);
        chk("pp_last_count", count, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("pp_empty", empty, 1);

        // Push/pop stream across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1, i[1], 32'h200 + i, 32'hC00 + i, 3'(i % 3), (i >= 2), 1);
        end
        chk("wrap_count", count, 2);
        chk("wrap_head", pop_addr, 32'h212);

        // Mid-cycle reset: state clears without waiting for an edge
        #2;
        HRESETn = 1'b0;
        #1;
        sb.delete();
        chk("mrst_empty", empty, 1);
        chk("mrst_count", count, 0);
        chk("mrst_full", full, 0);
        chk("mrst_addr", pop_addr, 0);

        // Push held during reset is ignored
        push      = 1'b1;
        push_addr = 32'h77;
        @(posedge HCLK);
        #1;
        chk("rst_ign_count", count, 0);
        push    = 1'b0;
        HRESETn = 1'b1;
`ifdef AHB_CMD_FIFO_ERR_EN
        chk("rst_clr_of", overflow, 0);
        chk("rst_clr_uf", underflow, 0);
`endif

        // First operation after release
        step(1, 1, 32'h300, 32'h3, 3'd2, 0, 1);
        chk("post_count", count, 1);
        chk("post_addr", pop_addr, 32'h300);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("post_empty", empty, 1);
        chk("post_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
